bids22_ledger: RTL and testbench
================================

# bids22_ledger

Settlement stage downstream of the bids22 auction controller. Samples the one-cycle `roundOver` pulse and the accompanying `X_win`/`Y_win`/`Z_win`/`maxBid` outputs. Validates the result, debits the winner's balance, and logs each round into a host-readable history FIFO. Holds the authoritative per-bidder balance ledger, loaded by the host.

## Interface
- `DEPTH`, 8: history FIFO entries; power of two, ≥2.
- `ROUND_W`, 8: round counter and record round-id width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `roundOver`  in  1  round-result strobe from the auction controller.
- `X_win`, `Y_win`, `Z_win`  in  1 each  winner flags; valid with `roundOver`.
- `maxBid`  in  32  winning amount; valid with `roundOver`.
- `ld_en`  in  1  balance load strobe.
- `ld_sel`  in  2  balance load target: 1=X, 2=Y, 3=Z, 0=ignored.
- `ld_data`  in  32  balance load value.
- `rd_en`  in  1  history pop request.
- `busy`  out  1  settlement in progress.
- `X_balance`, `Y_balance`, `Z_balance`  out  32 each  ledger balances.
- `settle_err`  out  2  result of the last settlement: 00 ok, 01 no winner, 10 insufficient funds, 11 multiple winners.
- `round_cnt`  out  ROUND_W  number of rounds settled.
- `rd_valid`  out  1  history FIFO is non-empty.
- `rd_data`  out  ROUND_W+36  head record, packed as {round_id, winner[1:0], err[1:0], amount[31:0]}.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `ovf`  out  1  sticky flag: a record was overwritten.
- `miss`  out  1  sticky flag: `roundOver` arrived while `busy`.

## Operation
- **Reset:** all outputs, balances, counters and FIFO pointers are zero; the FSM enters IDLE.
- **FSM:** IDLE → CHECK → DEBIT → LOG → IDLE.
- **IDLE:**
  - `ld_en` with `ld_sel` ≠ 0 writes `ld_data` to the selected balance.
  - When `roundOver` is high, the block captures the win flags and `maxBid`, raises `busy`, and moves to CHECK.
  - If `ld_en` and `roundOver` occur in the same cycle, both take effect; the check then uses the newly loaded balance.
- **CHECK:** decode the win flags.
  - Exactly one flag set: winner = 1/2/3 for X/Y/Z. If that winner's balance is less than the amount (unsigned), err = 10; otherwise err = 00.
  - No flag set: winner = 0, err = 01.
  - More than one flag set: winner = 0, err = 11.
  - `settle_err` is registered at the CHECK→DEBIT edge.
- **DEBIT:** if err = 00, the winner's balance is reduced by the amount. The result cannot underflow because CHECK guarantees balance ≥ amount. No other balance changes.
- **LOG:** push {round_cnt, winner, err, amount} into the FIFO, increment `round_cnt` (wraps modulo 2^ROUND_W), return to IDLE.
- **While not IDLE:**
  - `ld_en` is ignored.
  - `roundOver` is ignored and sets `miss`.
- **FIFO behaviour:**
  - Show-ahead: `rd_data` is the head entry whenever `rd_valid` is high.
  - `rd_en` with `rd_valid` pops at the clock edge; `rd_en` on an empty FIFO has no effect.
  - Push and pop in the same cycle: both occur and `fifo_count` is unchanged. This holds even when the FIFO is full.
  - Push when full with no pop: the oldest entry is dropped, the new entry is written, `fifo_count` stays at DEPTH, and `ovf` is set.
  - `rd_data` is zero when the FIFO is empty.

## Timing
- Edge E0 samples `roundOver`. At E1 `settle_err` updates; at E2 the balance updates; at E3 the record is written and `round_cnt` increments.
- `busy` is high from after E0 until after E3 (3 cycles).
- The earliest next `roundOver` accepted is at E4. Auction pacing (ResultSt→WaitSt→LockSt) guarantees at least this spacing.
- A balance load issued in IDLE is visible on the balance output one cycle later.
- `rd_valid` rises the cycle after E3 if the FIFO was empty.
- Asserting `reset_n` low mid-settlement aborts the settlement immediately. Balances and the FIFO are cleared, and no partial debit persists after reset.

## Structure
- Package `bids22_pkg` holds:
  - `winner_t` enum: NONE=0, X=1, Y=2, Z=3.
  - `settle_err_t` enum: OK, NOWIN, NOFUNDS, MULTI.
  - `ledger_state_t` enum: IDLE, CHECK, DEBIT, LOG.
  - `hist_rec_t` packed struct, parameterised by ROUND_W through a localparam.
- Sub-module `bids22_hist_fifo` (DEPTH, WIDTH): circular buffer with show-ahead read, overwrite-on-full, and count and overflow outputs.
- Top-level holds the FSM, balance registers and round counter.

## Test plan
- **Normal settlement:** load X=100, Y=50, Z=70; pulse `roundOver` with Y_win=1, maxBid=40.
  - 3 cycles later Y_balance=10 and `settle_err`=00.
  - FIFO record = {0, 2, 00, 40}; `round_cnt`=1.
- **Insufficient funds:** Z=30; `roundOver` with Z_win=1, maxBid=31.
  - `settle_err`=10 and Z_balance stays 30.
  - Record = {n, 3, 10, 31}.
- **Bad win flags:** `roundOver` with no win flags → `settle_err`=01, winner=0. `roundOver` with X_win=Y_win=1 → `settle_err`=11. Balances unchanged in both cases.
- **Busy collision:** second `roundOver` 2 cycles after the first.
  - The second is ignored and `miss`=1.
  - Exactly one record is written and `round_cnt` +1.
  - A `ld_en` during `busy` leaves the balance unchanged.
- **FIFO overwrite:** settle DEPTH+1 rounds with no reads.
  - `fifo_count`=DEPTH and `ovf`=1; the head has round_id 1.
  - Simultaneous `rd_en` and push when full keeps count at DEPTH and leaves `ovf` unchanged.
- **Reset mid-settlement:** drop `reset_n` during DEBIT.
  - All outputs are 0 asynchronously.
  - After release, a fresh load and round settle normally with round_id 0.

Source files
------------

// File: rtl/bids22_pkg.sv
// bids22_pkg: shared types for the bids22 settlement ledger and its history FIFO.
package bids22_pkg;
  localparam int HIST_ROUND_W = 8;
  localparam int AMT_W = 32;
  typedef enum logic [1:0] {NONE = 2'd0, X = 2'd1, Y = 2'd2, Z = 2'd3} winner_t;
  typedef enum logic [1:0] {OK = 2'd0, NOWIN = 2'd1, NOFUNDS = 2'd2, MULTI = 2'd3} settle_err_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, DEBIT = 2'd2, LOG = 2'd3} ledger_state_t;
  typedef struct packed {
    logic [HIST_ROUND_W-1:0] round_id;
    winner_t                 winner;
    settle_err_t             err;
    logic [AMT_W-1:0]        amount;
  } hist_rec_t;
  // Flags packed as {z, y, x}; anything other than exactly one set bit has no winner.
  function automatic winner_t decode_win(input logic [2:0] f);
    return f == 3'b001 ? X : f == 3'b010 ? Y : f == 3'b100 ? Z : NONE;
  endfunction
endpackage

// File: rtl/bids22_hist_fifo.sv
// bids22_hist_fifo: show-ahead circular history buffer that drops its oldest entry on overflow.
module bids22_hist_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 44
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, full, pop, drop;
  always_comb begin
    full    = cnt_q == CW'(DEPTH);
    valid_o = cnt_q != '0;
    pop     = pop_i && valid_o;
    drop    = push_i && !pop && full;
    rdata_o = valid_o ? mem_q[rd_q] : '0;
    count_o = cnt_q;
    ovf_o   = ovf_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop || drop) rd_q <= rd_q + 1'b1;
      if (push_i && !pop && !full) cnt_q <= cnt_q + 1'b1;
      else if (pop && !push_i) cnt_q <= cnt_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/bids22_ledger.sv
// bids22_ledger: validates auction results, debits the winner and logs each round to a history FIFO.
module bids22_ledger
  import bids22_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ROUND_W = HIST_ROUND_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   roundOver,
  input  logic                   X_win,
  input  logic                   Y_win,
  input  logic                   Z_win,
  input  logic [31:0]            maxBid,
  input  logic                   ld_en,
  input  logic [1:0]             ld_sel,
  input  logic [31:0]            ld_data,
  input  logic                   rd_en,
  output logic                   busy,
  output logic [31:0]            X_balance,
  output logic [31:0]            Y_balance,
  output logic [31:0]            Z_balance,
  output logic [1:0]             settle_err,
  output logic [ROUND_W-1:0]     round_cnt,
  output logic                   rd_valid,
  output logic [ROUND_W+35:0]    rd_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ovf,
  output logic                   miss
);
  ledger_state_t      state_q, state_d;
  logic [2:0]         flags_q;
  logic [31:0]        amt_q, chk_bal;
  winner_t            winner_q, chk_win;
  settle_err_t        err_q, chk_err;
  logic [31:0]        bal_q [3];
  logic [31:0]        bal_d [3];
  logic [ROUND_W-1:0] round_q;
  logic               miss_q, idle, push;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (roundOver ? CHECK : IDLE) :
              state_q == CHECK ? DEBIT :
              state_q == DEBIT ? LOG : IDLE;
  always_comb begin
    idle = state_q == IDLE;
    busy = !idle;
    push = state_q == LOG;
  end
  // Check reads bal_q one cycle after capture, so a load issued with roundOver is already visible.
  always_comb begin
    chk_win = decode_win(flags_q);
    chk_bal = chk_win == Y ? bal_q[1] : chk_win == Z ? bal_q[2] : bal_q[0];
    chk_err = flags_q == 3'b000 ? NOWIN :
              chk_win == NONE   ? MULTI :
              chk_bal < amt_q   ? NOFUNDS : OK;
  end
  always_comb
    for (int i = 0; i < 3; i++)
      bal_d[i] = (idle && ld_en && ld_sel == 2'(i + 1)) ? ld_data :
                 (state_q == DEBIT && err_q == OK && winner_q == 2'(i + 1)) ? bal_q[i] - amt_q :
                 bal_q[i];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bal_q    <= '{default: '0};
      flags_q  <= '0;
      amt_q    <= '0;
      winner_q <= NONE;
      err_q    <= OK;
      round_q  <= '0;
      miss_q   <= 1'b0;
    end else begin
      bal_q <= bal_d;
      if (idle && roundOver) begin
        flags_q <= {Z_win, Y_win, X_win};
        amt_q   <= maxBid;
      end
      if (state_q == CHECK) begin
        winner_q <= chk_win;
        err_q    <= chk_err;
      end
      if (push) round_q <= round_q + 1'b1;
      if (!idle && roundOver) miss_q <= 1'b1;
    end
  end
  always_comb begin
    X_balance  = bal_q[0];
    Y_balance  = bal_q[1];
    Z_balance  = bal_q[2];
    settle_err = err_q;
    round_cnt  = round_q;
    miss       = miss_q;
  end
  bids22_hist_fifo #(.DEPTH(DEPTH), .WIDTH(ROUND_W + 36)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (rd_en),
    .wdata_i ({round_q, winner_q, err_q, amt_q}),
    .valid_o (rd_valid),
    .rdata_o (rd_data),
    .count_o (fifo_count),
    .ovf_o   (ovf)
  );
endmodule

// File: tb/tb_bids22_ledger.sv
// tb_bids22_ledger: directed settlement, collision, overflow and reset scenarios with hand-computed results.
module tb_bids22_ledger;
  import bids22_pkg::*;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        roundOver = 1'b0, X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic [31:0] maxBid = '0, ld_data = '0;
  logic        ld_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  ld_sel = '0;
  logic        busy, rd_valid, ovf, miss;
  logic [31:0] X_balance, Y_balance, Z_balance;
  logic [1:0]  settle_err;
  logic [7:0]  round_cnt;
  logic [43:0] rd_data;
  logic [3:0]  fifo_count;
  int errs = 0, checks = 0;
  bids22_ledger #(.DEPTH(8), .ROUND_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .roundOver(roundOver), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .maxBid(maxBid), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data), .rd_en(rd_en), .busy(busy),
    .X_balance(X_balance), .Y_balance(Y_balance), .Z_balance(Z_balance), .settle_err(settle_err),
    .round_cnt(round_cnt), .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
    .ovf(ovf), .miss(miss)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [43:0] rec(input int rid, input int w, input int e, input logic [31:0] amt);
    return {8'(rid), 2'(w), 2'(e), amt};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] s, input logic [31:0] v);
    ld_en = 1'b1; ld_sel = s; ld_data = v;
    tick;
    ld_en = 1'b0; ld_sel = '0; ld_data = '0;
  endtask
  task automatic pop;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
  endtask
  // f is {z, y, x}; pop_e3 requests a pop on the edge that writes the record
  task automatic settle(input logic [2:0] f, input logic [31:0] bid, input logic pop_e3);
    {Z_win, Y_win, X_win} = f; maxBid = bid; roundOver = 1'b1;
    tick;
    {Z_win, Y_win, X_win} = '0; maxBid = '0; roundOver = 1'b0;
    tick;
    tick;
    rd_en = pop_e3;
    tick;
    rd_en = 1'b0;
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_busy", busy, 0);
    chk("rst_xbal", X_balance, 0);
    chk("rst_err", settle_err, 0);
    chk("rst_round", round_cnt, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf_miss", {ovf, miss}, 0);
    reset_n = 1'b1;
    tick;
    load(2'd1, 100);
    load(2'd2, 50);
    chk("ld_y", Y_balance, 50);
    load(2'd3, 70);
    Y_win = 1'b1; maxBid = 40; roundOver = 1'b1;
    tick;
    Y_win = 1'b0; maxBid = '0; roundOver = 1'b0;
    chk("n_busy_e0", busy, 1);
    tick;
    chk("n_err_e1", settle_err, 0);
    chk("n_ybal_e1", Y_balance, 50);
    tick;
    chk("n_ybal_e2", Y_balance, 10);
    chk("n_round_e2", round_cnt, 0);
    chk("n_valid_e2", rd_valid, 0);
    tick;
    chk("n_busy_e3", busy, 0);
    chk("n_round_e3", round_cnt, 1);
    chk("n_valid_e3", rd_valid, 1);
    chk("n_rec", rd_data, rec(0, 2, 0, 40));
    chk("n_count", fifo_count, 1);
    pop;
    chk("pop_valid", rd_valid, 0);
    chk("pop_rdata", rd_data, 0);
    pop;
    chk("pop_empty_count", fifo_count, 0);
    load(2'd3, 30);
    settle(3'b100, 31, 1'b0);
    chk("nf_err", settle_err, 2);
    chk("nf_zbal", Z_balance, 30);
    chk("nf_rec", rd_data, rec(1, 3, 2, 31));
    chk("nf_round", round_cnt, 2);
    pop;
    settle(3'b000, 5, 1'b0);
    chk("nw_err", settle_err, 1);
    chk("nw_rec", rd_data, rec(2, 0, 1, 5));
    settle(3'b011, 5, 1'b0);
    chk("mw_err", settle_err, 3);
    chk("mw_bal", {X_balance, Y_balance}, {32'd100, 32'd10});
    chk("mw_zbal", Z_balance, 30);
    chk("mw_count", fifo_count, 2);
    pop;
    chk("mw_rec", rd_data, rec(3, 0, 3, 5));
    pop;
    chk("col_miss0", miss, 0);
    X_win = 1'b1; maxBid = 20; roundOver = 1'b1;
    tick;
    X_win = 1'b0; maxBid = '0; roundOver = 1'b0;
    tick;
    roundOver = 1'b1; ld_en = 1'b1; ld_sel = 2'd1; ld_data = 999;
    tick;
    roundOver = 1'b0; ld_en = 1'b0; ld_sel = '0; ld_data = '0;
    tick;
    chk("col_miss", miss, 1);
    chk("col_xbal", X_balance, 80);
    chk("col_round", round_cnt, 5);
    chk("col_rec", rd_data, rec(4, 1, 0, 20));
    tick;
    tick;
    chk("col_busy", busy, 0);
    chk("col_count", fifo_count, 1);
    chk("col_round2", round_cnt, 5);
    pop;
    for (int i = 0; i < 8; i++) settle(3'b000, i, 1'b0);
    chk("full_count", fifo_count, 8);
    chk("full_ovf", ovf, 0);
    chk("full_head", rd_data, rec(5, 0, 1, 0));
    settle(3'b000, 100, 1'b1);
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", ovf, 0);
    chk("pp_head", rd_data, rec(6, 0, 1, 1));
    settle(3'b000, 200, 1'b0);
    chk("ow_count", fifo_count, 8);
    chk("ow_ovf", ovf, 1);
    chk("ow_head", rd_data, rec(7, 0, 1, 2));
    chk("ow_round", round_cnt, 15);
    X_win = 1'b1; maxBid = 10; roundOver = 1'b1;
    tick;
    X_win = 1'b0; maxBid = '0; roundOver = 1'b0;
    tick;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_bal", {X_balance, Y_balance, Z_balance}, 0);
    chk("ar_busy", busy, 0);
    chk("ar_round", round_cnt, 0);
    chk("ar_fifo", {rd_valid, fifo_count, ovf}, 0);
    chk("ar_rdata", rd_data, 0);
    chk("ar_miss_err", {miss, settle_err}, 0);
    tick;
    reset_n = 1'b1;
    tick;
    chk("ar_nodebit", X_balance, 0);
    load(2'd1, 60);
    settle(3'b001, 25, 1'b0);
    chk("post_xbal", X_balance, 35);
    chk("post_err", settle_err, 0);
    chk("post_rec", rd_data, rec(0, 1, 0, 25));
    chk("post_round", round_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
